seq_pattern_tx: RTL



---
 rtl/seq_tx_pkg.sv | 13 +
 rtl/pattern_shreg.sv | 37 +++
 rtl/seq_pattern_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types for the serial pattern transmitter: FSM state encoding and default idle level.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/pattern_shreg.sv
// Loadable left-shift register; exposes the MSB it will hold after this edge so the
// parent can register the serial output in step with the shift.
module pattern_shreg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] data_i,
    output logic             msbNext_o
);

    logic [PAT_W-1:0] shreg_q;
    logic [PAT_W-1:0] shreg_d;

    // Load wins over shift so a reload on the last bit of a repetition never shifts.
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msbNext_o = shreg_d[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first a requested number of
// times, with an optional one-cycle idle gap between repetitions, then pulses done.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int   PAT_W    = 4,
    parameter int   REP_W    = 4,
    parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PAT_W-1:0] req_pattern,
    input  logic [REP_W-1:0] req_reps,
    input  logic             req_gap_en,
    output logic             o,
    output logic             o_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(PAT_W);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAT_W - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [REP_W-1:0] repCnt_q, repCnt_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             gapEn_q, gapEn_d;
    logic             o_q, o_d;
    logic             oValid_q, oValid_d;
    logic             done_q, done_d;

    logic             shLoad;
    logic             shShift;
    logic [PAT_W-1:0] shLoadVal;
    logic             shNextMsb;

    pattern_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (shLoad),
        .shift_i  (shShift),
        .data_i   (shLoadVal),
        .msbNext_o(shNextMsb)
    );

    // Outputs are computed from the next state so they can be registered without adding latency.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        repCnt_d  = repCnt_q;
        pattern_d = pattern_q;
        gapEn_d   = gapEn_q;
        shLoad    = 1'b0;
        shShift   = 1'b0;
        shLoadVal = pattern_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pattern_d = req_pattern;
                    gapEn_d   = req_gap_en;
                    if (req_reps == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = SHIFT;
                        shLoad    = 1'b1;
                        shLoadVal = req_pattern;
                        bitCnt_d  = BIT_LAST;
                        repCnt_d  = req_reps;
                    end
                end
            end
            SHIFT: begin
                if (bitCnt_q == '0) begin
                    if (repCnt_q == REP_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        repCnt_d = repCnt_q - REP_W'(1);
                        if (gapEn_q) begin
                            state_d = GAP;
                        end else begin
                            shLoad   = 1'b1;
                            bitCnt_d = BIT_LAST;
                        end
                    end
                end else begin
                    shShift  = 1'b1;
                    bitCnt_d = bitCnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                state_d  = SHIFT;
                shLoad   = 1'b1;
                bitCnt_d = BIT_LAST;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        oValid_d = (state_d == SHIFT);
        o_d      = oValid_d ? shNextMsb : IDLE_BIT;
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            repCnt_q  <= '0;
            pattern_q <= '0;
            gapEn_q   <= 1'b0;
            o_q       <= IDLE_BIT;
            oValid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            repCnt_q  <= repCnt_d;
            pattern_q <= pattern_d;
            gapEn_q   <= gapEn_d;
            o_q       <= o_d;
            oValid_q  <= oValid_d;
            done_q    <= done_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign o         = o_q;
    assign o_valid   = oValid_q;
    assign done      = done_q;

endmodule
